// File: rtl/register.sv
// Register file: 2**ADDR_W x DATA_W, two combinational read ports, one synchronous write port.
// Define REGISTER_BYPASS_EN to forward writeData to a read port whose address matches an active write.
module register #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] address1,
  input  logic [ADDR_W-1:0] address2,
  input  logic [ADDR_W-1:0] writeAddress,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Next-state: only the addressed register changes, and only when write is high.
  always_comb begin
    regs_d = regs_q;
    if (write) begin
      regs_d[writeAddress] = writeData;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REGISTER_BYPASS_EN
  logic fwd1_c;
  logic fwd2_c;

  // Write-through forwarding is gated by reset so a write held during reset is never visible.
  always_comb begin
    fwd1_c = write && reset && (writeAddress == address1);
    fwd2_c = write && reset && (writeAddress == address2);
    data1  = fwd1_c ? writeData : regs_q[address1];
    data2  = fwd2_c ? writeData : regs_q[address2];
  end
`else
  always_comb begin
    data1 = regs_q[address1];
    data2 = regs_q[address2];
  end
`endif

endmodule

// File: tb/tb_register.sv
// Directed self-checking bench for the register file; collision expectations follow REGISTER_BYPASS_EN.
module tb_register;

  logic        clock;
  logic        reset;
  logic        write;
  logic [2:0]  address1;
  logic [2:0]  address2;
  logic [2:0]  writeAddress;
  logic [15:0] writeData;
  logic [15:0] data1;
  logic [15:0] data2;

  int n_checks = 0;
  int n_fail   = 0;

  register #(.DATA_W(16), .ADDR_W(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .write        (write),
    .address1     (address1),
    .address2     (address2),
    .writeAddress (writeAddress),
    .writeData    (writeData),
    .data1        (data1),
    .data2        (data2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [15:0] exp_c;

    reset        = 1'b0;
    write        = 1'b0;
    address1     = 3'd0;
    address2     = 3'd7;
    writeAddress = 3'd0;
    writeData    = 16'h0000;
    #1;
    chk("reset_d1_a0", data1, 16'h0000);
    chk("reset_d2_a7", data2, 16'h0000);
    tick();
    tick();
    #3 reset = 1'b1;
    tick();

    // Write walk: one-hot values into registers 0..7
    for (int i = 0; i < 8; i++) begin
      write        = 1'b1;
      writeAddress = 3'(i);
      writeData    = 16'(1) << i;
      address1     = 3'(i);
      tick();
      chk($sformatf("walk_reg%0d", i), data1, 16'(1) << i);
    end

    // Read-back sweep on both ports with write disabled and junk on writeData
    write     = 1'b0;
    writeData = 16'hDEAD;
    for (int i = 0; i < 8; i++) begin
      address1     = 3'(i);
      address2     = 3'(7 - i);
      writeAddress = 3'(i);
      #1;
      chk($sformatf("rb_d1_a%0d", i), data1, 16'(1) << i);
      chk($sformatf("rb_d2_a%0d", 7 - i), data2, 16'(1) << (7 - i));
    end
    tick();
    chk("rb_no_write_reg7", data1, 16'h0080);

    // Same-address collision on register 3
    address1     = 3'd3;
    writeAddress = 3'd3;
    writeData    = 16'hBEEF;
    write        = 1'b1;
    #1;
`ifdef REGISTER_BYPASS_EN
    exp_c = 16'hBEEF;
`else
    exp_c = 16'h0008;
`endif
    chk("collide_pre_edge", data1, exp_c);
    tick();
    chk("collide_post_edge", data1, 16'hBEEF);

    // Dual read of the same register
    writeAddress = 3'd5;
    writeData    = 16'h1234;
    tick();
    write    = 1'b0;
    address1 = 3'd5;
    address2 = 3'd5;
    #1;
    chk("dual_d1", data1, 16'h1234);
    chk("dual_d2", data2, 16'h1234);

    // Overwrite register 0 on consecutive edges
    address1     = 3'd0;
    writeAddress = 3'd0;
    write        = 1'b1;
    writeData    = 16'hFFFF;
    tick();
    chk("ovw_ffff", data1, 16'hFFFF);
    writeData = 16'h0000;
    tick();
    chk("ovw_0000", data1, 16'h0000);
    write    = 1'b0;
    address1 = 3'd5;
    #1;
    chk("pre_reset_reg5", data1, 16'h1234);

    // Async reset between edges: all registers read zero without a clock edge
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      address1 = 3'(i);
      address2 = 3'(7 - i);
      #1;
      chk($sformatf("arst_d1_a%0d", i), data1, 16'h0000);
      chk($sformatf("arst_d2_a%0d", 7 - i), data2, 16'h0000);
    end

    // Write attempt while reset is held is discarded
    write        = 1'b1;
    writeAddress = 3'd2;
    writeData    = 16'hAAAA;
    address1     = 3'd2;
    address2     = 3'd5;
    tick();
    chk("rst_write_ignored", data1, 16'h0000);

    // First edge after deassertion captures the pending write
    #2 reset = 1'b1;
    tick();
    chk("post_rst_write", data1, 16'hAAAA);
    chk("post_rst_other", data2, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
